add_sequencer: RTL and testbench
================================

Name: add_sequencer

Overview:
Multi-cycle controller that performs WIDTH-bit additions using the team's existing 4-bit ripple adder (addition) as a shared datapath slice. Operands are latched on a start handshake. The sequencer feeds one 4-bit slice per cycle, least-significant first, and chains each slice's carry_out into the next slice's carry_in. It reports the completed sum, carry and signed overflow with a one-cycle done pulse. It sits between the ALU operation decoder and the addition slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, derived local constant: number of 4-bit slices per operation (not overridable)

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; accepted only when ready=1
A  input  WIDTH  operand A, sampled on the accepted start cycle
B  input  WIDTH  operand B, sampled on the accepted start cycle
carry_in  input  1  initial carry into slice 0, sampled with A/B
ready  output  1  high in IDLE only; start is accepted when ready=1
busy  output  1  high while slices are being processed (RUN)
done  output  1  one-cycle pulse; Sum/carry_out/overflow valid from this cycle
Sum  output  WIDTH  result; held stable until the next accepted start
carry_out  output  1  carry out of the final slice
overflow  output  1  two's-complement overflow: (A[msb]==B[msb]) && (Sum[msb]!=A[msb])

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, slice counter=0, operand/carry registers=0, Sum=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
- FSM states are IDLE, RUN and DONE.
- IDLE: ready=1.
  - start=1 at a clk edge latches A, B and carry_in, clears the slice counter and moves to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN: busy=1, ready=0.
  - Each cycle, the adder receives operand bits [4k+3:4k] and the carry register, where k is the slice counter.
  - At the clk edge, the slice sum is written into Sum[4k+3:4k], carry register <= slice carry_out, and k increments.
  - When the edge completes slice k=NSLICE-1: carry_out <= final carry, overflow is computed from the latched sign bits and the final Sum msb, and the FSM moves to DONE.
- DONE: done=1 for exactly one cycle, ready=0, busy=0; the FSM then unconditionally returns to IDLE.
- Latency: start accepted at edge E0; slices complete at edges E1..E_NSLICE; done is high during the cycle after E_NSLICE. At the default WIDTH=16 this is 4 busy cycles, with done in cycle 5 after acceptance. Minimum issue interval is NSLICE+2 cycles.
- Sum bits are updated progressively during RUN; Sum is only valid while done=1 and afterwards until the next accepted start.
- start while ready=0 is ignored: no latch, no queueing, and the result is unaffected.
- A, B and carry_in changing after acceptance have no effect on the operation in flight.
- Wrap-around: the sum is taken mod 2^WIDTH; the carry is reported only on carry_out.
- Reset mid-operation aborts immediately. No done pulse is generated, and all outputs take their reset values.
- start held high continuously produces back-to-back operations, one accepted each time the FSM returns to IDLE.

Decomposition:
- Shared ALU package: slice width constant (4), FSM state encoding (IDLE/RUN/DONE, 2 bits), and a function computing NSLICE from WIDTH.
- One sub-module: the existing addition 4-bit adder, instantiated once and time-shared across slices.
- The counter and FSM stay inline in add_sequencer.

Test Plan:
1. A=0x0001, B=0x0002, carry_in=0, start pulse -> busy for 4 cycles, then done pulse with Sum=0x0003, carry_out=0, overflow=0; ready returns 1 the cycle after done.
2. A=0xFFFF, B=0x0001, carry_in=0 -> Sum=0x0000, carry_out=1, overflow=0. This checks carry ripple across all 4 slices.
3. A=0x7FFF, B=0x0001, carry_in=0 -> Sum=0x8000, carry_out=0, overflow=1. Also A=0x8000, B=0x8000, carry_in=1 -> Sum=0x0001, carry_out=1, overflow=1.
4. Start A=0x1234, B=0x1111. During RUN, pulse start with A=0xAAAA and change A/B -> done with Sum=0x2345, exactly one done pulse, and the second start is not queued.
5. Assert rst_n=0 during the 2nd RUN cycle of A=0x00FF, B=0x0001 -> immediately Sum=0, carry_out=0, overflow=0, done=0, busy=0, ready=1. After release, a new start of 0x0003+0x0004 gives Sum=0x0007.
6. Hold start=1 with A=0x0F0F, B=0x00F1 -> first done gives Sum=0x1000, and the second op is accepted the cycle after done. Repeat at WIDTH=4 (NSLICE=1): A=0xF, B=0x1 -> done 2 cycles after acceptance with Sum=0x0, carry_out=1.

Source files
------------

// File: rtl/add_sequencer_pkg.sv
// Shared ALU definitions: slice width, sequencer state encoding and slice-count helper.
package add_sequencer_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add_sequencer_addition.sv
// 4-bit ripple-carry adder slice; purely combinational.
module add_sequencer_addition
  import add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               carry_in,
  output logic [SLICE_W-1:0] sum_c,
  output logic               carry_out_c
);

  logic [SLICE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum_c    = '0;
    carry[0] = carry_in;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      sum_c[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    carry_out_c = carry[SLICE_W];
  end

endmodule

// File: rtl/add_sequencer.sv
// Multi-cycle WIDTH-bit adder: time-shares one 4-bit slice, LSB slice first,
// chaining the carry through a register between cycles.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NSLICE = calc_nslice(WIDTH);
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d, overflow_d;
  logic             ready_d, busy_d, done_d;

  int unsigned      slice_lsb_c;
  logic [SLICE_W-1:0] slice_a_c, slice_b_c, slice_sum_c;
  logic             slice_co_c;
  logic [WIDTH-1:0] sum_merge_c;

  // Operand slice selection and merge of the slice result into Sum
  always_comb begin
    slice_lsb_c = SLICE_W * 32'(cnt_q);
    slice_a_c   = SLICE_W'(a_q >> slice_lsb_c);
    slice_b_c   = SLICE_W'(b_q >> slice_lsb_c);
    sum_merge_c = (Sum & ~(WIDTH'({SLICE_W{1'b1}}) << slice_lsb_c))
                | (WIDTH'(slice_sum_c) << slice_lsb_c);
  end

  add_sequencer_addition u_addition (
    .a           (slice_a_c),
    .b           (slice_b_c),
    .carry_in    (carry_q),
    .sum_c       (slice_sum_c),
    .carry_out_c (slice_co_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = Sum;
    carry_out_d = carry_out;
    overflow_d  = overflow;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_merge_c;
        carry_d = slice_co_c;
        if (cnt_q == LAST_SLICE) begin
          carry_out_d = slice_co_c;
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (sum_merge_c[WIDTH-1] != a_q[WIDTH-1]);
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      Sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      Sum       <= sum_d;
      carry_out <= carry_out_d;
      overflow  <= overflow_d;
      ready     <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer at WIDTH=16 and WIDTH=4 with a result scoreboard.
module tb_add_sequencer;

  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, cin;
  logic [15:0] a, b;
  logic        ready, busy, done, co, ov;
  logic [15:0] sum;

  logic        start4, cin4;
  logic [3:0]  a4, b4;
  logic        ready4, busy4, done4, co4, ov4;
  logic [3:0]  sum4;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_sum = '0;

  add_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .carry_in(cin),
    .ready(ready), .busy(busy), .done(done), .Sum(sum),
    .carry_out(co), .overflow(ov)
  );

  add_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .carry_in(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .Sum(sum4),
    .carry_out(co4), .overflow(ov4)
  );

  function automatic exp_t model(input int unsigned w, input logic [15:0] x,
                                 input logic [15:0] y, input logic c);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] mask;
    mask  = 16'((17'd1 << w) - 17'd1);
    full  = 17'(x & mask) + 17'(y & mask) + 17'(c);
    e.sum = full[15:0] & mask;
    e.co  = full[w];
    e.ov  = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
    return e;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] s,
                              input logic c, input logic o);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=done expected=no_pending_op", tag);
    end else begin
      e = sb.pop_front();
      chk_w({tag, "_sum"}, s, e.sum);
      chk_b({tag, "_co"}, c, e.co);
      chk_b({tag, "_ov"}, o, e.ov);
      last_sum = e.sum;
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(16, x, y, c));
  endtask

  // Follow one operation from acceptance through its done cycle
  task automatic track16(input string tag, input bit hold, input bit disturb);
    for (int k = 1; k <= int'(NS) + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (disturb && k == 2) begin
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b1;
      end
      if (disturb && k == 3) start = 1'b0;
      if (k <= int'(NS)) begin
        chk_b({tag, "_busy"}, busy, 1'b1);
        chk_b({tag, "_ready_run"}, ready, 1'b0);
        chk_b({tag, "_done_run"}, done, 1'b0);
      end else begin
        chk_b({tag, "_done"}, done, 1'b1);
        chk_b({tag, "_busy_done"}, busy, 1'b0);
        chk_b({tag, "_ready_done"}, ready, 1'b0);
        check_result(tag, sum, co, ov);
      end
    end
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk_b({tag, "_ready_idle"}, ready, 1'b1);
    chk_b({tag, "_busy_idle"}, busy, 1'b0);
    chk_b({tag, "_done_idle"}, done, 1'b0);
    chk_w({tag, "_sum_held"}, sum, last_sum);
  endtask

  task automatic op4(input string tag, input logic [3:0] x, input logic [3:0] y,
                     input logic c);
    exp_t e;
    a4     = x;
    b4     = y;
    cin4   = c;
    start4 = 1'b1;
    e      = model(4, 16'(x), 16'(y), c);
    sb.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    chk_b({tag, "_busy"}, busy4, 1'b1);
    chk_b({tag, "_done_run"}, done4, 1'b0);
    @(negedge clk);
    chk_b({tag, "_done"}, done4, 1'b1);
    check_result(tag, 16'(sum4), co4, ov4);
    @(negedge clk);
    chk_b({tag, "_ready_idle"}, ready4, 1'b1);
    chk_b({tag, "_done_idle"}, done4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    cin4   = 1'b0;

    #12;
    chk_b("rst_ready", ready, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_w("rst_sum", sum, 16'h0000);
    chk_b("rst_co", co, 1'b0);
    chk_b("rst_ov", ov, 1'b0);
    chk_b("rst_ready4", ready4, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0001, 16'h0002, 1'b0);
    track16("t1", 1'b0, 1'b0);
    idle_after("t1");

    issue(16'hFFFF, 16'h0001, 1'b0);
    track16("t2", 1'b0, 1'b0);
    idle_after("t2");

    issue(16'h7FFF, 16'h0001, 1'b0);
    track16("t3a", 1'b0, 1'b0);
    idle_after("t3a");

    issue(16'h8000, 16'h8000, 1'b1);
    track16("t3b", 1'b0, 1'b0);
    idle_after("t3b");

    // Start pulse and operand changes mid-run must be ignored
    issue(16'h1234, 16'h1111, 1'b0);
    track16("t4", 1'b0, 1'b1);
    idle_after("t4");
    @(negedge clk);
    chk_b("t4_not_queued_busy", busy, 1'b0);
    chk_b("t4_not_queued_ready", ready, 1'b1);

    // Asynchronous reset during the second RUN cycle
    issue(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_b("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_w("t5_rst_sum", sum, 16'h0000);
    chk_b("t5_rst_co", co, 1'b0);
    chk_b("t5_rst_ov", ov, 1'b0);
    chk_b("t5_rst_done", done, 1'b0);
    chk_b("t5_rst_busy", busy, 1'b0);
    chk_b("t5_rst_ready", ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b0);
    track16("t5", 1'b0, 1'b0);
    idle_after("t5");

    // start held high: next op accepted the cycle after done
    issue(16'h0F0F, 16'h00F1, 1'b0);
    track16("t6a", 1'b1, 1'b0);
    @(negedge clk);
    chk_b("t6_ready_after_done", ready, 1'b1);
    chk_b("t6_done_after_done", done, 1'b0);
    issue(16'h0001, 16'h0001, 1'b0);
    track16("t6b", 1'b0, 1'b0);
    idle_after("t6b");

    op4("w4a", 4'hF, 4'h1, 1'b0);
    op4("w4b", 4'h7, 4'h1, 1'b0);

    chk_b("sb_empty", (sb.size() == 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
